// File: rtl/apb4_master_bridge_if.sv
// Command/response and APB4 signal bundle for apb4_master_bridge.
// The master modport is the bridge's view. The slave modport is the
// environment's view: the command source, the response sink and the
// APB completer.
interface apb4_master_bridge_if #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = APB_DATA_WIDTH / 8;

  // Command channel
  logic                      req_valid;
  logic                      req_ready;
  logic [APB_ADDR_WIDTH-1:0] req_addr;
  logic                      req_write;
  logic [APB_DATA_WIDTH-1:0] req_wdata;
  logic [STRB_WIDTH-1:0]     req_strb;
  logic [2:0]                req_prot;

  // Response channel
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata;
  logic                      rsp_err;
  logic                      rsp_timeout;

  // APB4 requester side
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [2:0]                pprot;
  logic                      pwrite;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0]     pstrb;
  logic                      psel;
  logic                      penable;
  logic                      pready;
  logic                      pslverr;
  logic [APB_DATA_WIDTH-1:0] prdata;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
    input  rsp_ready,
    input  pready, pslverr, prdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output paddr, pprot, pwrite, pwdata, pstrb, psel, penable
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
    output rsp_ready,
    output pready, pslverr, prdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  paddr, pprot, pwrite, pwdata, pstrb, psel, penable
  );
endinterface

// File: rtl/apb4_master_bridge.sv
// Single-outstanding bridge from a valid/ready command/response pair to an
// APB4 requester port, with an optional ACCESS-phase wait timeout.
// Every output comes straight from a flop.
module apb4_master_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                pclk,
  input  logic                presetn,
  apb4_master_bridge_if.master bus
);
  localparam int unsigned STRB_WIDTH = APB_DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                    state_q;
  logic [CNT_WIDTH-1:0]      wait_cnt_q;
  logic                      req_ready_q;
  logic                      rsp_valid_q;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q;
  logic                      rsp_err_q;
  logic                      rsp_timeout_q;
  logic                      psel_q;
  logic                      penable_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic                      pwrite_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_WIDTH-1:0]     pstrb_q;
  logic [2:0]                pprot_q;

  // Transfer sequencing. APB request fields are held from the accept until the
  // transfer is retired. pready, pslverr and prdata are looked at only in ACCESS.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            paddr_q     <= bus.req_addr;
            pwrite_q    <= bus.req_write;
            pprot_q     <= bus.req_prot;
            // Reads drive zero write data and strobes.
            pwdata_q    <= bus.req_write ? bus.req_wdata : '0;
            pstrb_q     <= bus.req_write ? bus.req_strb : '0;
            wait_cnt_q  <= '0;
            state_q     <= SETUP;
          end
        end

        SETUP: begin
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= ACCESS;
        end

        ACCESS: begin
          if (bus.pready) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata;
            rsp_err_q     <= bus.pslverr;
            rsp_timeout_q <= 1'b0;
            state_q       <= RESP;
          end else if (TIMEOUT_EN && (wait_cnt_q == CNT_LIMIT)) begin
            // Give up on the completer and report an error response.
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= RESP;
          end else if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_q <= wait_cnt_q + CNT_WIDTH'(1);
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Drive the bundle from the registers.
  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.pprot       = pprot_q;
endmodule

// File: doc/apb4_master_bridge.md
APB4_MASTER_BRIDGE -- requirements
Module: apb4_master_bridge

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, data width (multiple of 8); strobe width APB_DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, max ACCESS wait cycles; 0 disables timeout.
REQ-004 SHALL have one clock and an asynchronous active-low reset.
REQ-005 pclk  in  1  clock; all logic on rising edge.
REQ-006 presetn  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  command valid.
REQ-008 req_ready  out  1  bridge accepts command.
REQ-009 req_addr  in  APB_ADDR_WIDTH  target address.
REQ-010 req_write  in  1  1=write, 0=read.
REQ-011 req_wdata  in  APB_DATA_WIDTH  write data.
REQ-012 req_strb  in  APB_DATA_WIDTH/8  write byte strobes.
REQ-013 req_prot  in  3  protection type.
REQ-014 rsp_valid  out  1  response valid.
REQ-015 rsp_ready  in  1  response consumer ready.
REQ-016 rsp_rdata  out  APB_DATA_WIDTH  read data (0 for writes/timeouts).
REQ-017 rsp_err  out  1  pslverr seen or timeout.
REQ-018 rsp_timeout  out  1  transfer aborted by timeout.
REQ-019 paddr/pprot/pwrite/pwdata/pstrb  out  APB_ADDR_WIDTH/3/1/APB_DATA_WIDTH/APB_DATA_WIDTH/8  APB4 master request fields.
REQ-020 psel, penable  out  1 each  APB4 select and enable.
REQ-021 pready, pslverr  in  1 each  APB4 completer ready and error.
REQ-022 prdata  in  APB_DATA_WIDTH  APB4 read data.

Function
REQ-023 FSM states SHALL be IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-024 req_ready SHALL be 1 only in IDLE; req_valid&req_ready SHALL latch addr/write/wdata/strb/prot and go to SETUP.
REQ-025 SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS unconditionally; wait counter cleared.
REQ-026 ACCESS: psel=1, penable=1; pready=0 -> stay, counter +1 (saturating, width clog2(TIMEOUT_CYCLES+1)).
REQ-027 ACCESS with pready=1 -> RESP; capture rsp_rdata=prdata for reads (0 for writes), rsp_err=pslverr, rsp_timeout=0; psel=penable=0 next cycle.
REQ-028 Timeout: TIMEOUT_CYCLES!=0, pready=0 and counter==TIMEOUT_CYCLES -> RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0; psel/penable dropped; late pready ignored.
REQ-029 paddr/pprot/pwrite/pwdata/pstrb SHALL be stable from SETUP through last ACCESS cycle; for reads pstrb=0, pwdata=0.
REQ-030 pready/pslverr/prdata SHALL be ignored outside ACCESS.
REQ-031 RESP: rsp_valid=1, rsp_* stable until rsp_ready=1; then IDLE, rsp_valid=0 next cycle.
REQ-032 Latency: accept at cycle N -> psel at N+1, penable at N+2; pready=1 at N+2 -> rsp_valid at N+3; minimum 4 cycles per transfer with rsp_ready=1.
REQ-033 No new command SHALL be accepted while a response is pending (single outstanding).

Reset
REQ-034 presetn=0 SHALL immediately force IDLE and all outputs to 0 (req_ready=0 during reset, 1 from first cycle after release), including mid-transfer (psel drops asynchronously, response discarded).

Verification
REQ-035 Write addr=0x10, wdata=0xA5A5_0001, strb=0xF, pready=1 first ACCESS -> psel N+1, penable N+2, rsp_valid N+3, rsp_err=0, rsp_rdata=0.
REQ-036 Read addr=0x24, 3 pready=0 wait cycles then pready=1, prdata=0xDEAD_BEEF -> penable held 4 cycles, paddr stable, rsp_rdata=0xDEAD_BEEF, pstrb=0.
REQ-037 Read with pready=1, pslverr=1 -> rsp_err=1, rsp_timeout=0.
REQ-038 TIMEOUT_CYCLES=4, pready held 0 -> abort after 4 wait cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0; later pready pulse ignored.
REQ-039 rsp_ready held 0 for 5 cycles with req_valid=1 -> rsp_valid/rsp_* stable, req_ready=0, psel=0; second command accepted only after response handshake.
REQ-040 presetn asserted during ACCESS -> psel/penable/rsp_valid 0 same cycle; after release req_ready=1, no stale response.
